// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the SRAM interface. It latches the
// winning request at grant and returns NXM if the downstream never acknowledges.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned WORD_W  = 36,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_write_data,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_user,
    output logic [WORD_W-1:0] cpu_read_data,
    output logic              cpu_ack,
    output logic              cpu_nxm,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [WORD_W-1:0] dma_write_data,
    input  logic              dma_read,
    input  logic              dma_write,
    output logic [WORD_W-1:0] dma_read_data,
    output logic              dma_ack,
    output logic              dma_nxm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_user,
    input  logic [WORD_W-1:0] mem_read_data,
    input  logic              mem_ack,
    output logic              grant_dma
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_dma_q, last_dma_d;
    logic              grant_dma_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [WORD_W-1:0] mem_write_data_d;
    logic              mem_read_d, mem_write_d, mem_user_d;
    logic [WORD_W-1:0] cpu_read_data_d, dma_read_data_d;
    logic              cpu_ack_d, cpu_nxm_d, dma_ack_d, dma_nxm_d;

    logic              cpu_req, dma_req, pick_dma, gnt_req, timeout_hit, finish, wr_sel;
    logic [WORD_W-1:0] ret_data;

    assign cpu_req     = cpu_read | cpu_write;
    assign dma_req     = dma_read | dma_write;
    // On a tie the master that was not served last wins.
    assign pick_dma    = dma_req & (~cpu_req | ~last_dma_q);
    assign gnt_req     = grant_dma ? dma_req : cpu_req;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign finish      = mem_ack | timeout_hit;
    assign wr_sel      = pick_dma ? dma_write : cpu_write;
    assign ret_data    = (mem_ack & mem_read) ? mem_read_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cpu_req | dma_req) state_d = StBusy;
            StBusy:  if (finish) state_d = StDone;
            StDone:  if (!gnt_req && !mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d            = cnt_q;
        last_dma_d       = last_dma_q;
        grant_dma_d      = grant_dma;
        mem_addr_d       = mem_addr;
        mem_write_data_d = mem_write_data;
        mem_read_d       = mem_read;
        mem_write_d      = mem_write;
        mem_user_d       = mem_user;
        cpu_read_data_d  = cpu_read_data;
        cpu_ack_d        = cpu_ack;
        cpu_nxm_d        = cpu_nxm;
        dma_read_data_d  = dma_read_data;
        dma_ack_d        = dma_ack;
        dma_nxm_d        = dma_nxm;
        unique case (state_q)
            StIdle: begin
                if (cpu_req | dma_req) begin
                    grant_dma_d      = pick_dma;
                    mem_addr_d       = pick_dma ? dma_addr : cpu_addr;
                    mem_write_data_d = pick_dma ? dma_write_data : cpu_write_data;
                    mem_user_d       = ~pick_dma & cpu_user;
                    mem_write_d      = wr_sel;
                    mem_read_d       = ~wr_sel;
                    cnt_d            = '0;
                end
            end
            StBusy: begin
                if (finish) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // A master that gave up its request mid-cycle gets no ack.
                    if (gnt_req) begin
                        if (grant_dma) begin
                            dma_read_data_d = ret_data;
                            dma_ack_d       = 1'b1;
                            dma_nxm_d       = ~mem_ack;
                        end else begin
                            cpu_read_data_d = ret_data;
                            cpu_ack_d       = 1'b1;
                            cpu_nxm_d       = ~mem_ack;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (!gnt_req && !mem_ack) begin
                    cpu_ack_d  = 1'b0;
                    cpu_nxm_d  = 1'b0;
                    dma_ack_d  = 1'b0;
                    dma_nxm_d  = 1'b0;
                    last_dma_d = grant_dma;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            last_dma_q     <= 1'b1;
            grant_dma      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_user       <= 1'b0;
            cpu_read_data  <= '0;
            cpu_ack        <= 1'b0;
            cpu_nxm        <= 1'b0;
            dma_read_data  <= '0;
            dma_ack        <= 1'b0;
            dma_nxm        <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            last_dma_q     <= last_dma_d;
            grant_dma      <= grant_dma_d;
            mem_addr       <= mem_addr_d;
            mem_write_data <= mem_write_data_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            mem_user       <= mem_user_d;
            cpu_read_data  <= cpu_read_data_d;
            cpu_ack        <= cpu_ack_d;
            cpu_nxm        <= cpu_nxm_d;
            dma_read_data  <= dma_read_data_d;
            dma_ack        <= dma_ack_d;
            dma_nxm        <= dma_nxm_d;
        end
    end

endmodule
